// File: rtl/cmd_uart_wrapper.sv
// Frames host UART bytes into 16-bit commands (high byte first) and forwards 8-bit responses to the UART transmitter.
// Optional inter-byte timeout enabled by defining COMM_TIMEOUT_EN.
module cmd_uart_wrapper #(
   parameter int unsigned TIMEOUT_CYC = 50000,
   parameter int unsigned TO_W        = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rx_rdy,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        resp_sent,
   output logic        trmt,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   output logic        frame_err
);

   typedef enum logic {WAIT_HI, WAIT_LO} rx_state_e;
   typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;

   // Reject configurations whose counter cannot represent the terminal count
   if (TIMEOUT_CYC < 2 || 64'(TIMEOUT_CYC - 1) >= (64'(1) << TO_W)) begin : g_bad_cfg
      $error("cmd_uart_wrapper: TO_W too narrow for TIMEOUT_CYC");
   end

   rx_state_e   rx_state_q, rx_state_d;
   tx_state_e   tx_state_q, tx_state_d;
   logic [15:0] cmd_q, cmd_d;
   logic        cmd_rdy_q, cmd_rdy_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        trmt_q, trmt_d;
   logic        resp_sent_q, resp_sent_d;
`ifdef COMM_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            frame_err_q, frame_err_d;
`endif

   // Receive framing: high byte, then low byte; set of cmd_rdy wins over clear
   always_comb begin
      rx_state_d = rx_state_q;
      cmd_d      = cmd_q;
      cmd_rdy_d  = cmd_rdy_q;
      clr_rx_rdy = 1'b0;
`ifdef COMM_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
      frame_err_d = 1'b0;
`endif
      if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
      case (rx_state_q)
         WAIT_HI: begin
            if (rx_rdy) begin
               cmd_d[15:8] = rx_data;
               cmd_rdy_d   = 1'b0;
               clr_rx_rdy  = 1'b1;
               rx_state_d  = WAIT_LO;
`ifdef COMM_TIMEOUT_EN
               to_cnt_d = '0;
`endif
            end
         end
         WAIT_LO: begin
            if (rx_rdy) begin
               cmd_d[7:0] = rx_data;
               cmd_rdy_d  = 1'b1;
               clr_rx_rdy = 1'b1;
               rx_state_d = WAIT_HI;
            end
`ifdef COMM_TIMEOUT_EN
            else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
               rx_state_d  = WAIT_HI;
               frame_err_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
`endif
         end
      endcase
   end

   // Transmit handshake: one start strobe per accepted response
   always_comb begin
      tx_state_d  = tx_state_q;
      tx_data_d   = tx_data_q;
      trmt_d      = 1'b0;
      resp_sent_d = resp_sent_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (send_resp) begin
               tx_data_d   = resp;
               trmt_d      = 1'b1;
               resp_sent_d = 1'b0;
               tx_state_d  = TX_BUSY;
            end
         end
         TX_BUSY: begin
            if (tx_done) begin
               resp_sent_d = 1'b1;
               tx_state_d  = TX_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_state_q  <= WAIT_HI;
         tx_state_q  <= TX_IDLE;
         cmd_q       <= '0;
         cmd_rdy_q   <= 1'b0;
         tx_data_q   <= '0;
         trmt_q      <= 1'b0;
         resp_sent_q <= 1'b0;
`ifdef COMM_TIMEOUT_EN
         to_cnt_q    <= '0;
         frame_err_q <= 1'b0;
`endif
      end else begin
         rx_state_q  <= rx_state_d;
         tx_state_q  <= tx_state_d;
         cmd_q       <= cmd_d;
         cmd_rdy_q   <= cmd_rdy_d;
         tx_data_q   <= tx_data_d;
         trmt_q      <= trmt_d;
         resp_sent_q <= resp_sent_d;
`ifdef COMM_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
         frame_err_q <= frame_err_d;
`endif
      end
   end

   assign cmd       = cmd_q;
   assign cmd_rdy   = cmd_rdy_q;
   assign tx_data   = tx_data_q;
   assign trmt      = trmt_q;
   assign resp_sent = resp_sent_q;
`ifdef COMM_TIMEOUT_EN
   assign frame_err = frame_err_q;
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Bench for cmd_uart_wrapper: directed vector table, hand sequences and a randomized run against a reference model.
module tb_cmd_uart_wrapper;

   localparam int unsigned TO_CYC = 16;

   logic        clk, rst_n;
   logic        rx_rdy, clr_rx_rdy, cmd_rdy, clr_cmd_rdy;
   logic [7:0]  rx_data, resp, tx_data;
   logic [15:0] cmd;
   logic        send_resp, resp_sent, trmt, tx_done, frame_err;

   int n_checks = 0;
   int n_fail   = 0;

   cmd_uart_wrapper #(.TIMEOUT_CYC(TO_CYC), .TO_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
      .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
      .resp_sent(resp_sent), .trmt(trmt), .tx_data(tx_data),
      .tx_done(tx_done), .frame_err(frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: what the host has framed so far and what the transmitter owes
   logic [15:0] m_cmd;
   logic        m_rdy, m_lo, m_busy, m_trmt, m_sent, m_fe;
   logic [7:0]  m_tx;
   int          m_wait;

   function automatic void model_clock();
      logic set_rdy, clr_rdy;
      set_rdy = 1'b0;
      clr_rdy = clr_cmd_rdy;
      if (!rst_n) begin
         m_cmd = '0; m_rdy = 0; m_lo = 0; m_busy = 0; m_trmt = 0;
         m_sent = 0; m_fe = 0; m_tx = '0; m_wait = 0;
         return;
      end
      m_trmt = 1'b0;
      m_fe   = 1'b0;
      if (rx_rdy) begin
         if (!m_lo) begin
            m_cmd  = {rx_data, m_cmd[7:0]};
            clr_rdy = 1'b1;
            m_lo   = 1'b1;
            m_wait = 0;
         end else begin
            m_cmd   = {m_cmd[15:8], rx_data};
            set_rdy = 1'b1;
            m_lo    = 1'b0;
         end
      end
`ifdef COMM_TIMEOUT_EN
      else if (m_lo) begin
         m_wait++;
         if (m_wait == int'(TO_CYC)) begin
            m_lo = 1'b0;
            m_fe = 1'b1;
         end
      end
`endif
      if (set_rdy) m_rdy = 1'b1;
      else if (clr_rdy) m_rdy = 1'b0;
      if (!m_busy) begin
         if (send_resp) begin
            m_tx = resp; m_trmt = 1'b1; m_sent = 1'b0; m_busy = 1'b1;
         end
      end else if (tx_done) begin
         m_sent = 1'b1; m_busy = 1'b0;
      end
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: combinational strobe check, edge, then full output comparison
   task automatic tick();
      #1;
      if (rst_n) chk("clr_rx_rdy", 16'(clr_rx_rdy), 16'(rx_rdy));
      @(posedge clk);
      model_clock();
      @(negedge clk);
      chk("cmd", cmd, m_cmd);
      chk("cmd_rdy", 16'(cmd_rdy), 16'(m_rdy));
      chk("tx_data", 16'(tx_data), 16'(m_tx));
      chk("trmt", 16'(trmt), 16'(m_trmt));
      chk("resp_sent", 16'(resp_sent), 16'(m_sent));
      chk("frame_err", 16'(frame_err), 16'(m_fe));
   endtask

   task automatic idle_inputs();
      rx_rdy = 0; rx_data = '0; clr_cmd_rdy = 0; send_resp = 0; resp = '0; tx_done = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_rdy = 1'b1; rx_data = b;
      tick();
      rx_rdy = 1'b0;
   endtask

   typedef struct {
      logic        rx_rdy;
      logic [7:0]  rx_data;
      logic        clr_cmd;
      logic [15:0] exp_cmd;
      logic        exp_rdy;
   } vec_t;

   vec_t tbl[11];
   int   fe_cnt;

   initial begin
      tbl[0]  = '{1'b1, 8'h46, 1'b0, 16'h4600, 1'b0};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 16'h4600, 1'b0};
      tbl[2]  = '{1'b1, 8'h16, 1'b0, 16'h4616, 1'b1};
      tbl[3]  = '{1'b0, 8'h00, 1'b1, 16'h4616, 1'b0};
      tbl[4]  = '{1'b1, 8'h80, 1'b0, 16'h8016, 1'b0};
      tbl[5]  = '{1'b0, 8'h00, 1'b0, 16'h8016, 1'b0};
      tbl[6]  = '{1'b1, 8'h00, 1'b1, 16'h8000, 1'b1};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 16'h8000, 1'b1};
      tbl[8]  = '{1'b1, 8'h12, 1'b0, 16'h1200, 1'b0};
      tbl[9]  = '{1'b1, 8'h34, 1'b0, 16'h1234, 1'b1};
      tbl[10] = '{1'b0, 8'h00, 1'b1, 16'h1234, 1'b0};

      m_cmd = '0; m_rdy = 0; m_lo = 0; m_busy = 0; m_trmt = 0;
      m_sent = 0; m_fe = 0; m_tx = '0; m_wait = 0;
      do_reset();
      chk("rst_cmd", cmd, 16'h0000);
      chk("rst_cmd_rdy", 16'(cmd_rdy), 16'h0);
      chk("rst_tx_data", 16'(tx_data), 16'h0);
      chk("rst_trmt", 16'(trmt), 16'h0);
      chk("rst_resp_sent", 16'(resp_sent), 16'h0);

      // Framing vectors, including clear colliding with completion
      for (int i = 0; i < 11; i++) begin
         rx_rdy = tbl[i].rx_rdy; rx_data = tbl[i].rx_data; clr_cmd_rdy = tbl[i].clr_cmd;
         tick();
         chk("tbl_cmd", cmd, tbl[i].exp_cmd);
         chk("tbl_rdy", 16'(cmd_rdy), 16'(tbl[i].exp_rdy));
      end
      idle_inputs();

      // Response path; send while busy is dropped
      do_reset();
      resp = 8'hA5; send_resp = 1'b1; tick();
      chk("tx_start_trmt", 16'(trmt), 16'h1);
      chk("tx_start_data", 16'(tx_data), 16'h00A5);
      resp = 8'h00; tick();
      chk("tx_busy_trmt", 16'(trmt), 16'h0);
      chk("tx_busy_data", 16'(tx_data), 16'h00A5);
      send_resp = 1'b0; tick();
      tx_done = 1'b1; tick();
      chk("tx_done_sent", 16'(resp_sent), 16'h1);
      tick();
      chk("tx_idle_done_trmt", 16'(trmt), 16'h0);
      chk("tx_idle_done_sent", 16'(resp_sent), 16'h1);
      tx_done = 1'b0;

      // Command completes while transmitter is busy
      resp = 8'h3C; send_resp = 1'b1; tick();
      send_resp = 1'b0;
      send_byte(8'h12); send_byte(8'h34);
      chk("par_cmd", cmd, 16'h1234);
      chk("par_rdy", 16'(cmd_rdy), 16'h1);
      chk("par_tx_data", 16'(tx_data), 16'h003C);
      chk("par_sent", 16'(resp_sent), 16'h0);
      tx_done = 1'b1; tick(); tx_done = 1'b0;
      chk("par_done", 16'(resp_sent), 16'h1);

      // Lone high byte followed by a long gap
      do_reset();
      fe_cnt = 0;
      send_byte(8'hC1);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (frame_err === 1'b1) fe_cnt++;
      end
      send_byte(8'h80);
`ifdef COMM_TIMEOUT_EN
      chk("to_fe_count", 16'(fe_cnt), 16'd1);
      send_byte(8'h00);
      chk("to_cmd", cmd, 16'h8000);
      chk("to_rdy", 16'(cmd_rdy), 16'h1);
`else
      chk("noto_fe_count", 16'(fe_cnt), 16'd0);
      chk("noto_cmd", cmd, 16'hC180);
      chk("noto_rdy", 16'(cmd_rdy), 16'h1);
      send_byte(8'h00);
`endif

      // Low byte landing exactly on the timeout cycle still completes
      do_reset();
      fe_cnt = 0;
      send_byte(8'h55);
      for (int i = 0; i < int'(TO_CYC) - 1; i++) begin
         tick();
         if (frame_err === 1'b1) fe_cnt++;
      end
      send_byte(8'hAA);
      tick();
      if (frame_err === 1'b1) fe_cnt++;
      chk("edge_fe_count", 16'(fe_cnt), 16'd0);
      chk("edge_cmd", cmd, 16'h55AA);
      chk("edge_rdy", 16'(cmd_rdy), 16'h1);

      // Reset discards a partial command
      do_reset();
      send_byte(8'h46);
      do_reset();
      chk("mid_rst_cmd", cmd, 16'h0000);
      chk("mid_rst_rdy", 16'(cmd_rdy), 16'h0);
      send_byte(8'h05); send_byte(8'h16);
      chk("post_rst_cmd", cmd, 16'h0516);
      chk("post_rst_rdy", 16'(cmd_rdy), 16'h1);

      // Randomized traffic on both paths
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst_n       = ($urandom_range(0, 299) != 0);
         rx_rdy      = ($urandom_range(0, 3) == 0) || (i % 500 > 480 && i % 500 < 484);
         if (i % 500 > 440 && i % 500 <= 480) rx_rdy = 1'b0;
         rx_data     = 8'($urandom);
         clr_cmd_rdy = ($urandom_range(0, 7) == 0);
         send_resp   = ($urandom_range(0, 5) == 0);
         resp        = 8'($urandom);
         tx_done     = ($urandom_range(0, 4) == 0);
         tick();
      end
      rst_n = 1'b1;
      idle_inputs();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
